dvp_pattern_tx: RTL and testbench

DVP_PATTERN_TX -- requirements
Module: dvp_pattern_tx

---
 rtl/dvp_pattern_tx.sv | 188 ++++++++++++++++++
 tb/tb_dvp_pattern_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_pattern_tx.sv
// DVP test-pattern transmitter.
// Generates a DVP-style stream (pixel clock, VSYNC, HREF, 10-bit data)
// from a frame timing FSM and one of four pattern generators.
// Optional build macro: DVP_TX_FRAME_STAMP_EN. When it is defined, pixels 0 and 1
// of line 0 carry the frame counter and its inverse.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no frame; pixel clock parked low; waits for I_en
// ST_VSYNC  | VSYNC_LEN lines with O_vsync high
// ST_VBACK  | V_BACK lines of vertical back porch
// ST_ACTIVE | V_ACTIVE lines; HREF high for the first H_ACTIVE PP of a line
// ST_VFRONT | V_FRONT lines of front porch, then frame_done and back to IDLE
module dvp_pattern_tx #(
    parameter int H_ACTIVE  = 800,
    parameter int H_BLANK   = 64,
    parameter int V_ACTIVE  = 600,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 8,
    parameter int V_FRONT   = 8
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_en,
    input  logic [1:0] I_mode,
    input  logic [9:0] I_const,
    output logic       O_pixclk,
    output logic       O_vsync,
    output logic       O_href,
    output logic [9:0] O_pixdata,
    output logic       O_busy,
    output logic       O_frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int BAR_W   = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t      state_q,  state_d;
    logic        pixclk_q, pixclk_d;
    logic [12:0] hcnt_q,   hcnt_d;    // pixel position within the line
    logic [10:0] lines_q,  lines_d;   // lines left in the current state (down-counter)
    logic [10:0] y_q,      y_d;
    logic [9:0]  f_q,      f_d;
    logic [1:0]  mode_q,   mode_d;
    logic [9:0]  const_q,  const_d;
    logic        vsync_q,  vsync_d;
    logic        href_q,   href_d;
    logic [9:0]  pix_q,    pix_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    function automatic logic [9:0] pattern(input logic [12:0] x, input logic [9:0] y,
                                           input logic [1:0] mode, input logic [9:0] cval,
                                           input logic [9:0] f);
        logic [2:0] bar;
        logic [9:0] p;
        bar = 3'(x / 13'(BAR_W));
        case (mode)
            2'd0:    p = x[9:0] + y + f;
            2'd1:    p = 10'(bar * 10'd146);
            2'd2:    p = cval;
            default: p = (x[3] ^ y[3]) ? 10'h3FF : 10'h000;
        endcase
        return p;
    endfunction

    // Frame timing, parameter latching and next-value computation of the registered outputs.
    // Position only advances on the edge that drives the pixel clock low, so the outputs,
    // which are derived from the next position, only change on that edge.
    always_comb begin
        state_d  = state_q;
        pixclk_d = pixclk_q;
        hcnt_d   = hcnt_q;
        lines_d  = lines_q;
        y_d      = y_q;
        f_d      = f_q;
        mode_d   = mode_q;
        const_d  = const_q;
        done_d   = 1'b0;

        if (state_q == ST_IDLE) begin
            pixclk_d = 1'b0;
            if (I_en) begin
                state_d = ST_VSYNC;
                hcnt_d  = '0;
                lines_d = 11'(VSYNC_LEN - 1);
                y_d     = '0;
                mode_d  = I_mode;
                const_d = I_const;
            end
        end else if (!pixclk_q) begin
            pixclk_d = 1'b1;
        end else begin
            pixclk_d = 1'b0;
            if (hcnt_q != 13'(H_TOTAL - 1)) begin
                hcnt_d = hcnt_q + 13'd1;
            end else begin
                hcnt_d = '0;
                if (lines_q != '0) begin
                    lines_d = lines_q - 11'd1;
                    if (state_q == ST_ACTIVE) y_d = y_q + 11'd1;
                end else begin
                    case (state_q)
                        ST_VSYNC: begin
                            state_d = ST_VBACK;
                            lines_d = 11'(V_BACK - 1);
                        end
                        ST_VBACK: begin
                            state_d = ST_ACTIVE;
                            lines_d = 11'(V_ACTIVE - 1);
                            y_d     = '0;
                        end
                        ST_ACTIVE: begin
                            state_d = ST_VFRONT;
                            lines_d = 11'(V_FRONT - 1);
                        end
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            f_d     = f_q + 10'd1;
                        end
                    endcase
                end
            end
        end

        vsync_d = (state_d == ST_VSYNC);
        busy_d  = (state_d != ST_IDLE);
        href_d  = (state_d == ST_ACTIVE) && (hcnt_d < 13'(H_ACTIVE));
        pix_d   = '0;
        if (href_d) begin
            pix_d = pattern(hcnt_d, y_d[9:0], mode_d, const_d, f_d);
`ifdef DVP_TX_FRAME_STAMP_EN
            if (y_d == '0 && hcnt_d == 13'd0) pix_d = f_d;
            if (y_d == '0 && hcnt_d == 13'd1) pix_d = ~f_d;
`endif
        end
    end

    // State, counters and registered outputs; synchronous reset clears everything.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q  <= ST_IDLE;
            pixclk_q <= 1'b0;
            hcnt_q   <= '0;
            lines_q  <= '0;
            y_q      <= '0;
            f_q      <= '0;
            mode_q   <= '0;
            const_q  <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            pix_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pixclk_q <= pixclk_d;
            hcnt_q   <= hcnt_d;
            lines_q  <= lines_d;
            y_q      <= y_d;
            f_q      <= f_d;
            mode_q   <= mode_d;
            const_q  <= const_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            pix_q    <= pix_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign O_pixclk     = pixclk_q;
    assign O_vsync      = vsync_q;
    assign O_href       = href_q;
    assign O_pixdata    = pix_q;
    assign O_busy       = busy_q;
    assign O_frame_done = done_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Bench for dvp_pattern_tx: frame-offset reference model checked every cycle,
// plus literal expectations on captured frames.
module tb_dvp_pattern_tx;

    localparam int HA = 16, HB = 4, VA = 4, VS = 2, VB = 2, VF = 2;
    localparam int HT = HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * HT * 2;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [1:0] mode;
    logic [9:0] cst;
    logic       pixclk, vsync, href, busy, done;
    logic [9:0] pix;

    dvp_pattern_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                     .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_mode(mode), .I_const(cst),
        .O_pixclk(pixclk), .O_vsync(vsync), .O_href(href), .O_pixdata(pix),
        .O_busy(busy), .O_frame_done(done));

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    bit chk_en = 0;

    // reference model: a frame is just a cycle offset t since its start
    bit       m_act = 0, m_done = 0;
    int       m_t = 0, m_f = 0, m_mode = 0, m_const = 0;

    function automatic int pix_model(int x, int y, int md, int c, int f);
        int p;
        case (md)
            0: p = (x + y + f) % 1024;
            1: p = (x / (HA / 8)) * 146;
            2: p = c;
            default: p = (((x / 8) + (y / 8)) % 2 == 1) ? 1023 : 0;
        endcase
`ifdef DVP_TX_FRAME_STAMP_EN
        if (y == 0 && x == 0) p = f;
        if (y == 0 && x == 1) p = 1023 - f;
`endif
        return p;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_act = 0; m_t = 0; m_f = 0; m_done = 0;
        end else if (!m_act) begin
            m_done = 0;
            if (en) begin
                m_act = 1; m_t = 0; m_mode = int'(mode); m_const = int'(cst);
            end
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_act = 0; m_done = 1; m_f = (m_f + 1) % 1024;
            end
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        int pp, line, xx;
        logic [14:0] e, a;
        bit e_pc, e_vs, e_hr;
        int e_px;
        if (chk_en) begin
            pp = m_t / 2; line = pp / HT; xx = pp % HT;
            e_pc = m_act && (m_t % 2 == 1);
            e_vs = m_act && line < VS;
            e_hr = m_act && line >= VS + VB && line < VS + VB + VA && xx < HA;
            e_px = e_hr ? pix_model(xx, line - VS - VB, m_mode, m_const, m_f) : 0;
            e = {e_pc, e_vs, e_hr, m_act, m_done, 10'(e_px)};
            a = {pixclk, vsync, href, busy, done, pix};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle %0d outputs {pixclk,vsync,href,busy,done,pix}: got %h expected %h",
                         cyc, a, e);
            end
        end
    end

    // per-frame statistics and pixel capture from DUT outputs
    int cap [VA][HA];
    int vs_cnt = 0, hl = 0, hp = 0, hbad = 0, start_cyc = 0, done_cnt = 0;
    int last_vs = 0, last_hp = 0, last_hbad = 0, last_len = 0;
    bit busy_p = 0, href_p = 0;
    always @(negedge clk) begin
        int pp, line, xx;
        if (rst) begin
            vs_cnt = 0; hl = 0; hp = 0; hbad = 0;
        end else begin
            pp = m_t / 2; line = pp / HT; xx = pp % HT;
            if (m_act && (m_t % 2 == 1) && line >= VS + VB && line < VS + VB + VA && xx < HA)
                cap[line - VS - VB][xx] = int'(pix);
            if (busy && !busy_p) start_cyc = cyc;
            if (vsync) vs_cnt++;
            if (href) hl++;
            else if (href_p) begin
                hp++;
                if (hl != 32) hbad++;
                hl = 0;
            end
            if (done) begin
                last_vs = vs_cnt; last_hp = hp; last_hbad = hbad; last_len = cyc - start_cyc;
                done_cnt++;
                vs_cnt = 0; hp = 0; hbad = 0;
            end
        end
        busy_p = busy; href_p = href;
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!done && n < 1000);
        check("frame_done_wait", int'(done), 1);
        #1;
    endtask

    task automatic wait_start();
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while (!busy && n < 100);
        check("frame_start_wait", int'(busy), 1);
    endtask

    initial begin
        int dc, seglen;
        rst = 1; en = 0; mode = 0; cst = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        #1;
        check("reset_outputs", int'({pixclk, vsync, href, busy, done, pix}), 0);
        @(negedge clk);
        rst = 0;

        // frames 0..2 back to back, mode 0
        en = 1; mode = 0;
        wait_done();
        check("f0_first_pixel", cap[0][0], 0);
        check("f0_pixel_x15_y3", cap[3][15], 18);
        check("f0_vsync_cycles", last_vs, 80);
        check("f0_href_pulses", last_hp, 4);
        check("f0_href_bad_len", last_hbad, 0);
        check("f0_frame_len", last_len, 400);
        wait_done();
        wait_start();
        en = 0;
        wait_done();
`ifdef DVP_TX_FRAME_STAMP_EN
        check("f2_stamp_x0", cap[0][0], 'h002);
        check("f2_stamp_x1", cap[0][1], 'h3FD);
`else
        check("f2_ramp_x0", cap[0][0], 2);
        check("f2_ramp_x1", cap[0][1], 3);
`endif
        repeat (5) @(negedge clk);

        // colour bars; mode changed after start must be ignored
        mode = 1; en = 1;
        wait_start();
        en = 0; mode = 3;
        wait_done();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
`ifdef DVP_TX_FRAME_STAMP_EN
                if (y == 0 && x < 2) continue;
`endif
                check($sformatf("bars_y%0d_x%0d", y, x), cap[y][x], (x / 2) * 146);
            end
        repeat (3) @(negedge clk);

        // constant; I_const changed mid-frame
        mode = 2; cst = 10'h2A5; en = 1;
        wait_start();
        en = 0;
        repeat (150) @(negedge clk);
        cst = 10'h000; mode = 0;
        wait_done();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
`ifdef DVP_TX_FRAME_STAMP_EN
                if (y == 0 && x < 2) continue;
`endif
                check($sformatf("const_y%0d_x%0d", y, x), cap[y][x], 'h2A5);
            end

        // I_en dropped during ACTIVE line 1
        mode = 2'($urandom_range(0, 3)); en = 1;
        wait_start();
        repeat (210) @(negedge clk);
        en = 0;
        dc = done_cnt;
        wait_done();
        repeat (60) @(negedge clk);
        #1;
        check("endrop_done_pulses", done_cnt - dc, 1);
        check("endrop_busy_low", int'(busy), 0);
        check("endrop_pixclk_low", int'(pixclk), 0);

        // reset during VBACK, then a fresh frame from f=0
        mode = 0; en = 1;
        wait_start();
        repeat (100) @(negedge clk);
        rst = 1;
        @(negedge clk);
        #1;
        check("midrst_outputs", int'({pixclk, vsync, href, busy, done, pix}), 0);
        rst = 0;
        wait_start();
        en = 0;
        wait_done();
        check("rst_f0_x0_y0", cap[0][0], 0);
        check("rst_f0_x3_y1", cap[1][3], 4);
        check("rst_f0_x15_y3", cap[3][15], 18);

        // randomized enable, mode, const and reset activity
        for (int s = 0; s < 24; s++) begin
            en = ($urandom_range(0, 9) < 7);
            mode = 2'($urandom_range(0, 3));
            cst = 10'($urandom);
            seglen = $urandom_range(1, 500);
            for (int i = 0; i < seglen; i++) begin
                @(negedge clk);
                rst = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 31) == 0) cst = 10'($urandom);
            end
        end
        rst = 0; en = 0;
        repeat (450) @(negedge clk);
        #1;
        check("final_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
